// File: rtl/mux8bit_arb_pkg.sv
// ----------------------------------------------------------------------------
// mux8bit_arb_pkg
// Shared types and constants for the mux8bit round-robin arbiter slice.
//   state_t : arbiter ownership state (IDLE / OWN0 / OWN1), 2 bits
//   DATA_W  : datapath byte width
//   STAT_W  : grant statistics counter width
// ----------------------------------------------------------------------------
package mux8bit_arb_pkg;

    localparam int DATA_W = 8;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

endpackage

// File: rtl/mux8bit.sv
// ----------------------------------------------------------------------------
// mux8bit
// Plain 2:1 byte selector.
// Ports:
//   i0  : input byte selected when sel = 0
//   i1  : input byte selected when sel = 1
//   sel : select
//   y   : selected byte
// ----------------------------------------------------------------------------
module mux8bit
    import mux8bit_arb_pkg::*;
(
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux8bit_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux8bit_rr_arbiter
// Shares one mux8bit between two valid/ready requesters. Round-robin
// arbitration with bounded burst ownership; the selected byte is captured in
// a one-entry output register with a valid/ready handshake.
//
// Handshake: a byte moves on any interface in a cycle where valid and ready
// are both high at the rising clock edge. reqN_ready is only asserted when
// reqN_valid is high, the output stage can load, and N holds the grant.
// Upstream data/valid may change freely while not acknowledged.
//
// Parameters:
//   BURST_MAX : beats a requester may keep the grant while the other waits (1..15)
//   CNT_W     : beat counter width, must hold BURST_MAX
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   req0_valid/data/ready  : requester 0 (mux input i0)
//   req1_valid/data/ready  : requester 1 (mux input i1)
//   out_valid/data/src     : registered selected byte and its source
//   out_ready              : downstream consumes out_data
//   stat_cnt0/stat_cnt1    : saturating grant counters
//
// Build option: define MUX8BIT_ARB_STATS_EN to enable the grant counters;
// otherwise stat_cnt0/stat_cnt1 are tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module mux8bit_rr_arbiter
    import mux8bit_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last;     // most recent grantee; contention goes to !last

    logic              can_load;
    logic              g;        // granted requester
    logic              g_any;    // some requester holds the grant
    logic              hold;     // current owner continues its burst
    logic              xfer;
    logic [DATA_W-1:0] mux_y;

    assign can_load = !out_valid || out_ready;

    always_comb begin
        g     = 1'b0;
        g_any = 1'b0;
        hold  = 1'b0;
        if (state == OWN0 && req0_valid && cnt < BURST_LIM) begin
            g     = 1'b0;
            g_any = 1'b1;
            hold  = 1'b1;
        end else if (state == OWN1 && req1_valid && cnt < BURST_LIM) begin
            g     = 1'b1;
            g_any = 1'b1;
            hold  = 1'b1;
        end else if (req0_valid && req1_valid) begin
            g     = !last;
            g_any = 1'b1;
        end else if (req0_valid) begin
            g     = 1'b0;
            g_any = 1'b1;
        end else if (req1_valid) begin
            g     = 1'b1;
            g_any = 1'b1;
        end
    end

    assign req0_ready = can_load && g_any && !g && req0_valid;
    assign req1_ready = can_load && g_any &&  g && req1_valid;
    assign xfer       = req0_ready || req1_ready;

    mux8bit u_mux (
        .i0  (req0_data),
        .i1  (req1_data),
        .sel (g),
        .y   (mux_y)
    );

    // A burst that hit its limit with no competitor falls through to the
    // single-requester path (hold=0), so the re-grant restarts cnt at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (can_load) begin
            if (xfer) begin
                out_data  <= mux_y;
                out_src   <= g;
                out_valid <= 1'b1;
                last      <= g;
                if (hold) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    state <= g ? OWN1 : OWN0;
                    cnt   <= CNT_W'(1);
                end
            end else begin
                out_valid <= 1'b0;
                state     <= IDLE;
                cnt       <= '0;
            end
        end
    end

`ifdef MUX8BIT_ARB_STATS_EN
    logic [STAT_W-1:0] stat0_q;
    logic [STAT_W-1:0] stat1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (req0_ready && stat0_q != {STAT_W{1'b1}})
                stat0_q <= stat0_q + STAT_W'(1);
            if (req1_ready && stat1_q != {STAT_W{1'b1}})
                stat1_q <= stat1_q + STAT_W'(1);
        end
    end

    assign stat_cnt0 = stat0_q;
    assign stat_cnt1 = stat1_q;
`else
    assign stat_cnt0 = '0;
    assign stat_cnt1 = '0;
`endif

endmodule
